ram_mem_responder: RTL

RAM_MEM_RESPONDER -- requirements
Module: ram_mem_responder

---
 rtl/ram_mem_responder.sv | 125 ++++++++++++
 1 files changed

// File: rtl/ram_mem_responder.sv
// Shared backing-store responder for NUM_BANKS cache banks: round-robin grant,
// fixed LATENCY wait, one-cycle RESPOND with broadcast read data and a per-bank complete pulse.
module ram_mem_responder #(
  parameter int NUM_BANKS     = 4,
  parameter int LATENCY       = 4,
  parameter int MEM_WORDS     = 1024,
  parameter int CACHE_RW_SIZE = 32
) (
  input  logic                                     CLK,
  input  logic                                     nRST,
  input  logic [NUM_BANKS-1:0]                     ram_mem_REN,
  input  logic [NUM_BANKS-1:0]                     ram_mem_WEN,
  input  logic [NUM_BANKS-1:0][31:0]               ram_mem_addr,
  input  logic [NUM_BANKS-1:0][CACHE_RW_SIZE-1:0]  ram_mem_store,
  output logic [CACHE_RW_SIZE-1:0]                 ram_mem_data,
  output logic [NUM_BANKS-1:0]                     ram_mem_complete,
  output logic                                     resp_busy,
  output logic                                     proto_err
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int CW = $clog2(LATENCY + 1);
  localparam int BW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESPOND} state_t;

  typedef struct packed {
    logic [BW-1:0]            bank;
    logic                     rw;
    logic [AW-1:0]            idx;
    logic [CACHE_RW_SIZE-1:0] store;
  } access_t;

  state_t                   state, state_nxt;
  logic [CW-1:0]            cnt;
  logic [BW-1:0]            last_grant;
  access_t                  lat;
  logic [CACHE_RW_SIZE-1:0] mem [MEM_WORDS];

  logic [NUM_BANKS-1:0]     req;
  logic                     gnt_found;
  logic [BW-1:0]            gnt_bank;
  logic [NUM_BANKS-1:0]     unused_addr_bits;

  assign req = ram_mem_REN | ram_mem_WEN;

  // Byte-offset and above-depth address bits never select a word.
  always_comb begin
    unused_addr_bits = '0;
    for (int b = 0; b < NUM_BANKS; b++)
      unused_addr_bits[b] = ^{ram_mem_addr[b][31:2+AW], ram_mem_addr[b][1:0]};
  end

  // Round-robin search starting one past the previous winner.
  always_comb begin
    int k;
    gnt_found = 1'b0;
    gnt_bank  = '0;
    k         = 0;
    for (int i = 1; i <= NUM_BANKS; i++) begin
      k = (int'(last_grant) + i) % NUM_BANKS;
      if (!gnt_found && req[BW'(k)]) begin
        gnt_found = 1'b1;
        gnt_bank  = BW'(k);
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (|req)      state_nxt = BUSY;
      BUSY:    if (cnt == '0) state_nxt = RESPOND;
      RESPOND:                state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_comb begin
    resp_busy        = (state != IDLE);
    ram_mem_complete = '0;
    ram_mem_data     = '0;
    if (state == RESPOND) begin
      for (int b = 0; b < NUM_BANKS; b++)
        ram_mem_complete[b] = (lat.bank == BW'(b));
      if (!lat.rw) ram_mem_data = mem[lat.idx];
    end
  end

  // Access is captured once at grant; inputs are ignored until back in IDLE.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt        <= '0;
      last_grant <= BW'(NUM_BANKS - 1);
      lat        <= '0;
      proto_err  <= 1'b0;
    end else begin
      if (state == IDLE && gnt_found) begin
        lat.bank   <= gnt_bank;
        lat.rw     <= ram_mem_WEN[gnt_bank];
        lat.idx    <= ram_mem_addr[gnt_bank][2 +: AW];
        lat.store  <= ram_mem_store[gnt_bank];
        cnt        <= CW'(LATENCY - 1);
        last_grant <= gnt_bank;
        if (ram_mem_REN[gnt_bank] && ram_mem_WEN[gnt_bank]) proto_err <= 1'b1;
      end else if (state == BUSY && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < MEM_WORDS; i++) mem[i] <= '0;
    end else if (state == RESPOND && lat.rw) begin
      mem[lat.idx] <= lat.store;
    end
  end

endmodule
